interfaz_pago: RTL
==================

# interfaz_pago

Payment front-end for the washing machine: the initiating side of the coin/finalize handshake consumed by the washer controller. It debounces the raw coin sensor and emits one single-cycle `intro_moneda` pulse per accepted coin. It issues a single-cycle `finalizar_pago` on the pay button or on an inactivity timeout, and returns coins it cannot accept. It sits between the coin slot/user panel and the washer controller, sharing its clock and reset.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive samples at a new level required before the debounced coin level changes (≥1).
- `TIMEOUT_CYCLES`, 100: idle cycles in COBRANDO before automatic finalize (≥2).
- `MAX_MONEDAS`, 9: maximum coins forwarded per transaction (≤15).
- `clk` in 1: single system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `coin_sensor` in 1: raw, bouncy slot sensor; high while a coin passes.
- `boton_pagar` in 1: pay button, already clean and synchronous; only its rising edge is used.
- `intro_moneda` out 1: one-cycle pulse per accepted coin.
- `finalizar_pago` out 1: one-cycle pulse ending the transaction.
- `devolver_moneda` out 1: one-cycle pulse per rejected coin.
- `monedas` out 4: coins forwarded in the current transaction.
- `cobrando` out 1: high while in COBRANDO.

## Operation
- All outputs are registered. Reset values:
  - `intro_moneda`, `finalizar_pago`, `devolver_moneda`, `cobrando`: 0.
  - `monedas`: 0.
  - Debounced level: 0. Debounce counter, timeout counter and pending flag: cleared.
  - State: IDLE.
- Debouncer:
  - Counts consecutive samples that differ from the debounced level. The count resets on any sample equal to that level.
  - The level flips when the count reaches `DEBOUNCE_CYCLES`.
  - A 0→1 flip of the debounced level is a coin event. A 1→0 flip produces no event.
- FSM states: IDLE, COBRANDO, CERRADO.
- IDLE:
  - Coin event → `intro_moneda`, `monedas`=1, timeout loaded with `TIMEOUT_CYCLES`, go to COBRANDO.
  - Button edges are ignored.
- COBRANDO:
  - Coin event with `monedas` < `MAX_MONEDAS` → `intro_moneda`, `monedas`+1, timeout reloaded.
  - Coin event with `monedas` = `MAX_MONEDAS` → `devolver_moneda`; count and timeout unchanged.
  - Timeout decrements every cycle in which no coin is accepted. On reaching 0, finalize.
  - Button rising edge → finalize.
  - Finalize: emit `finalizar_pago`, then go to CERRADO.
- CERRADO:
  - Every coin event → `devolver_moneda`.
  - Button edges are ignored.
  - `monedas` holds the final value.
  - The only exit is `reset`, matching the washer controller, whose mode outputs clear only on reset.
- Ordering rule: `finalizar_pago` is never high in the same cycle as `intro_moneda`. It is never high in the cycle immediately after one either. This guarantees the downstream coin counter has settled before finalize is sampled.
- Conflicts: if a finalize cause (button edge or timeout) coincides with, or falls inside the guard window of, an `intro_moneda`, it sets the pending flag. The pending finalize fires at the first legal cycle. Coins arriving while the flag is set are still processed normally (accepted or returned).
- `intro_moneda` and `devolver_moneda` are mutually exclusive.

## Timing
- Coin latency:
  - Sensor first sampled high at edge k and stable through edge k+D-1 (D = `DEBOUNCE_CYCLES`): the debounced level rises at edge k+D-1.
  - The `intro_moneda`/`devolver_moneda` pulse is high in the cycle after edge k+D.
- Button latency: `boton_pagar` sampled 1 at edge m after 0 at edge m-1 → `finalizar_pago` high in the cycle after edge m+1, subject to the ordering rule.
- Timeout: with no further coins after the pulse for the last accepted coin, `finalizar_pago` asserts `TIMEOUT_CYCLES`+1 cycles after that pulse.
- Glitches shorter than D samples in either direction produce no event.
- Reset mid-operation:
  - Takes effect at the sampling edge and overrides all other activity in that cycle.
  - Any in-flight pulse is dropped.
  - A sensor held high through reset is counted as a new coin after D samples.
- `monedas` updates in the same cycle as its `intro_moneda` pulse.

## Test plan
- Clean coins: D=4, three clean coins (6-cycle highs, 6-cycle gaps), then button → three `intro_moneda` pulses, `monedas`=3, one `finalizar_pago` no earlier than 2 cycles after the last coin pulse, `cobrando` falls.
- Bounce: sensor pattern 1,0,1,1,0 then low → no pulse. Same followed by 4 stable highs → exactly one `intro_moneda` at the specified latency.
- Overflow: 11 coins → 9 `intro_moneda`, 2 `devolver_moneda`, `monedas`=9. Button → `finalizar_pago`. A 12th coin in CERRADO → `devolver_moneda`.
- Timeout: TIMEOUT_CYCLES=10, one coin, no button → `finalizar_pago` exactly 11 cycles after the `intro_moneda` pulse. A further button press → no second finalize.
- Simultaneous events: button edge timed so its finalize lands in the same cycle as an `intro_moneda` → finalize deferred to 2 cycles after that pulse, `monedas` includes the coin.
- Reset mid-operation: reset asserted mid-transaction with `monedas`=2 → next cycle all outputs 0, state IDLE. A new coin then starts a fresh transaction with `monedas`=1.

Source files
------------

// File: rtl/interfaz_pago.sv
// rtl/interfaz_pago.sv - coin debouncer and pay/finalize handshake front-end for the washer controller
//
// Purpose:
//    Debounces the raw coin sensor, forwards accepted coins as single-cycle
//    pulses, returns coins beyond the per-transaction limit or after the
//    transaction has closed, and ends the transaction on the pay button or
//    on inactivity. Finalize is never issued in, or right after, a coin pulse.
//
// Ports:
//    i_clk             system clock, rising edge
//    i_reset           synchronous, active-high
//    i_coin_sensor     raw, bouncy coin slot sensor (high while a coin passes)
//    i_boton_pagar     clean, synchronous pay button (rising edge used)
//    o_intro_moneda    one-cycle pulse per accepted coin
//    o_finalizar_pago  one-cycle pulse ending the transaction
//    o_devolver_moneda one-cycle pulse per returned coin
//    o_monedas         coins forwarded in the current transaction
//    o_cobrando        high while collecting coins
module interfaz_pago #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TIMEOUT_CYCLES  = 100,
   parameter int MAX_MONEDAS     = 9
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_coin_sensor,
   input  logic       i_boton_pagar,
   output logic       o_intro_moneda,
   output logic       o_finalizar_pago,
   output logic       o_devolver_moneda,
   output logic [3:0] o_monedas,
   output logic       o_cobrando
);

   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TMW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMW-1:0] TM_LOAD = TMW'(TIMEOUT_CYCLES);
   localparam logic [3:0]     MON_MAX = 4'(MAX_MONEDAS);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_COBRANDO = 2'd1;
   localparam logic [1:0] ST_CERRADO  = 2'd2;

   logic [DBW-1:0] r_db_cnt;
   logic           r_db_level;
   logic           r_db_prev;
   logic           r_btn_prev;
   logic           r_btn_evt;
   logic           r_pending;
   logic [TMW-1:0] r_timer;
   logic [1:0]     r_state;

   logic [1:0]     w_state_next;
   logic           w_coin_evt;
   logic           w_accept;
   logic           w_reject;
   logic           w_fin_cause;
   logic           w_fin_fire;

   // Debouncer: the level flips on the D-th consecutive differing sample.
   // r_db_prev delays the level one cycle so the coin event is a registered
   // rising edge, consumed by the FSM on the following edge.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_db_cnt   <= '0;
         r_db_level <= 1'b0;
         r_db_prev  <= 1'b0;
         r_btn_prev <= 1'b0;
         r_btn_evt  <= 1'b0;
      end else begin
         r_db_prev  <= r_db_level;
         r_btn_prev <= i_boton_pagar;
         r_btn_evt  <= i_boton_pagar & ~r_btn_prev;
         if (i_coin_sensor != r_db_level) begin
            if (r_db_cnt == DB_LAST) begin
               r_db_level <= i_coin_sensor;
               r_db_cnt   <= '0;
            end else begin
               r_db_cnt <= r_db_cnt + 1'b1;
            end
         end else begin
            r_db_cnt <= '0;
         end
      end
   end

   always_comb begin
      w_coin_evt  = r_db_level & ~r_db_prev;
      w_accept    = w_coin_evt &
                    ((r_state == ST_IDLE) | ((r_state == ST_COBRANDO) & (o_monedas < MON_MAX)));
      w_reject    = w_coin_evt & ~w_accept;
      w_fin_cause = (r_state == ST_COBRANDO) & (r_btn_evt | (r_timer == '0));
      // Finalize may not share a cycle with a coin pulse nor follow one
      // directly; a blocked cause is parked in r_pending until legal.
      w_fin_fire  = (r_state == ST_COBRANDO) & (w_fin_cause | r_pending) &
                    ~w_accept & ~o_intro_moneda;
      w_state_next = r_state;
      if ((r_state == ST_IDLE) && w_accept) begin
         w_state_next = ST_COBRANDO;
      end else if (w_fin_fire) begin
         w_state_next = ST_CERRADO;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state           <= ST_IDLE;
         r_timer           <= '0;
         r_pending         <= 1'b0;
         o_intro_moneda    <= 1'b0;
         o_finalizar_pago  <= 1'b0;
         o_devolver_moneda <= 1'b0;
         o_monedas         <= 4'd0;
         o_cobrando        <= 1'b0;
      end else begin
         r_state           <= w_state_next;
         o_cobrando        <= (w_state_next == ST_COBRANDO);
         o_intro_moneda    <= w_accept;
         o_devolver_moneda <= w_reject;
         o_finalizar_pago  <= w_fin_fire;

         if (w_accept) begin
            o_monedas <= o_monedas + 1'b1;
            r_timer   <= TM_LOAD;
         end else if ((r_state == ST_COBRANDO) && (r_timer != '0)) begin
            r_timer <= r_timer - 1'b1;
         end

         if (w_fin_fire) begin
            r_pending <= 1'b0;
         end else if (w_fin_cause) begin
            r_pending <= 1'b1;
         end
      end
   end

endmodule
